pwm_seq_scheduler: RTL and testbench
====================================

# pwm_seq_scheduler

Sequencer that fires the pattern-PWM channels one after another in a programmed order, with a programmable gap between channels and a programmable number of passes. It sits between the UART register mapper, which supplies configuration and the start/abort strobes, and the pattern_pwm channel instances. It issues one-cycle enable strobes and consumes each channel's busy/valid handshake. It runs in the clk_50M_o domain alongside the 100 kHz slow-PWM generator.

## Interface
Parameters:
- NUM_CH, 3: number of sequenced channels, 1..8.
- GAP_W, 16: width of the gap counter.
- TMO_W, 24: width of the timeout counter.

Ports:
- clk_50M_o  in  1  sequencer clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle strobe that begins a sequence; honoured only in IDLE.
- abort  in  1  one-cycle strobe that stops the sequence; wins over start.
- ch_mask  in  NUM_CH  channels included in the sequence; captured at start.
- gap_cycles  in  GAP_W  idle cycles inserted after each channel completes; captured at start.
- repeat_num  in  8  number of passes; 0 = repeat until abort; captured at start.
- tmo_cycles  in  TMO_W  per-channel completion timeout; 0 = disabled; captured at start.
- ch_busy  in  NUM_CH  channel busy indications, for status only.
- ch_valid  in  NUM_CH  channel completion pulses.
- ch_en  out  NUM_CH  one-hot, one-cycle enable strobe to the active channel.
- seq_busy  out  1  high in every state except IDLE.
- seq_done  out  1  one-cycle pulse when the sequence completes normally.
- seq_err  out  1  sticky error flag; cleared by the next accepted start.
- cur_ch  out  3  index of the active channel.
- pass_cnt  out  8  number of completed passes.

## Operation
- States: IDLE, ARM, WAIT, GAP, NEXT, DONE.
- IDLE + start:
  - Capture mask, gap, repeat and timeout.
  - Clear seq_err and pass_cnt.
  - Set cur_ch to the lowest set mask bit.
  - Go to ARM.
- IDLE + start with ch_mask == 0: go to DONE, set seq_err = 1.
- ARM: assert ch_en[cur_ch] for exactly one cycle, then go to WAIT.
- WAIT:
  - Wait for ch_valid[cur_ch].
  - ch_valid on any other channel is ignored.
  - On ch_valid[cur_ch], go to GAP.
- GAP:
  - Count gap_cycles cycles, then go to NEXT.
  - A gap of 0 spends exactly one cycle in GAP.
- NEXT:
  - Pick the next set mask bit above cur_ch and go to ARM.
  - If no such bit exists, increment pass_cnt.
  - If repeat_num != 0 and pass_cnt then equals repeat_num, go to DONE.
  - Otherwise wrap to the lowest set bit and go to ARM.
- DONE: pulse seq_done for one cycle, then go to IDLE.
- abort in any non-IDLE state:
  - Go to IDLE on the next edge.
  - Force ch_en to 0.
  - No seq_done pulse.
  - seq_err and pass_cnt are held.
- start while seq_busy is high: ignored.
- pass_cnt wraps 255 -> 0 when repeat_num == 0 (infinite mode).
- Reset values: state IDLE; ch_en 0, seq_busy 0, seq_done 0, seq_err 0, cur_ch 0, pass_cnt 0.
- Reset mid-sequence: all outputs return to their reset values immediately (asynchronous); no strobe is pending after reset deassertion.

## Timing
- All outputs are registered.
- start sampled at edge T: ch_en of the first channel is high from edge T+1 to edge T+2.
- ch_valid[cur_ch] sampled at edge V: the next channel's ch_en rises at edge V + max(gap_cycles,1) + 2.
- Completion of the final channel at edge V: seq_done is high from edge V + max(gap_cycles,1) + 2 for one cycle, and seq_busy falls one edge later.
- abort sampled at edge A: seq_busy is low after edge A+1.

## Configuration
- SEQ_TIMEOUT_EN defined:
  - A TMO_W counter runs in WAIT.
  - When tmo_cycles != 0 and the count reaches tmo_cycles with no ch_valid, set seq_err = 1 and go to GAP as if the channel had completed.
- SEQ_TIMEOUT_EN undefined:
  - No counter is built and tmo_cycles is ignored.
  - WAIT lasts until ch_valid or abort.
  - seq_err is set only by an empty mask.

## Test plan
- mask=3'b101, gap=4, repeat=1, valid returned 10 cycles after each ch_en -> ch_en 001 then 100, ch_en edges 16 cycles apart, one seq_done, pass_cnt=1, seq_err=0.
- mask=3'b111, gap=0, repeat=2 -> ch_en order 0,1,2,0,1,2, seq_done once, pass_cnt=2.
- mask=0, start -> seq_done one cycle after the DONE transition, seq_err=1, ch_en never asserted.
- repeat=0, mask=3'b010, abort after the 3rd ch_en -> seq_busy low after 2 edges, no seq_done, pass_cnt=2.
- SEQ_TIMEOUT_EN, tmo=100, channel 0 never returns valid -> seq_err=1 101 cycles after ch_en; sequence proceeds to channel 1.
- rst_n low during GAP, start re-issued with mask=3'b001 -> all outputs 0 during reset; sequence runs cleanly after reset.

Source files
------------

// File: rtl/pwm_seq_scheduler.sv
// Sequencer firing pattern_pwm channels in mask order with gap and pass control.
// Optional per-channel completion timeout is built when SEQ_TIMEOUT_EN is defined.
module pwm_seq_scheduler #(
  parameter int NUM_CH = 3,
  parameter int GAP_W  = 16,
  parameter int TMO_W  = 24
) (
  input  logic              clk_50M_o,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [GAP_W-1:0]  gap_cycles,
  input  logic [7:0]        repeat_num,
  input  logic [TMO_W-1:0]  tmo_cycles,
  input  logic [NUM_CH-1:0] ch_busy,
  input  logic [NUM_CH-1:0] ch_valid,
  output logic [NUM_CH-1:0] ch_en,
  output logic              seq_busy,
  output logic              seq_done,
  output logic              seq_err,
  output logic [2:0]        cur_ch,
  output logic [7:0]        pass_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARM  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_NEXT = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]        r_state;
  logic [NUM_CH-1:0] r_mask;
  logic [NUM_CH-1:0] r_ch_en;
  logic [GAP_W-1:0]  r_gap;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [7:0]        r_repeat;
  logic [7:0]        r_pass;
  logic [2:0]        r_cur;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic [2:0]        w_first_new;
  logic [2:0]        w_first;
  logic [2:0]        w_next;
  logic              w_found_new;
  logic              w_found;
  logic              w_has_next;
  logic              w_valid_cur;
  logic [NUM_CH-1:0] w_onehot;
  logic              w_tmo_hit;
  logic              w_gap_end;

`ifdef SEQ_TIMEOUT_EN
  logic [TMO_W-1:0]  r_tmo;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic              w_cfg_unused;

  assign w_cfg_unused = ^ch_busy;
  assign w_tmo_hit    = (r_tmo != '0) && (r_tmo_cnt == r_tmo);
`else
  logic              w_cfg_unused;

  assign w_cfg_unused = ^{tmo_cycles, ch_busy};
  assign w_tmo_hit    = 1'b0;
`endif

  assign w_gap_end = (r_gap == '0) || (r_gap_cnt == r_gap - GAP_W'(1));

  // Ascending scan with found flags gives lowest-index priority.
  always_comb begin
    w_first_new = '0;
    w_first     = '0;
    w_next      = '0;
    w_found_new = 1'b0;
    w_found     = 1'b0;
    w_has_next  = 1'b0;
    w_valid_cur = 1'b0;
    w_onehot    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch_mask[i] && !w_found_new) begin
        w_first_new = 3'(i);
        w_found_new = 1'b1;
      end
      if (r_mask[i] && !w_found) begin
        w_first = 3'(i);
        w_found = 1'b1;
      end
      if (r_mask[i] && (3'(i) > r_cur) && !w_has_next) begin
        w_next     = 3'(i);
        w_has_next = 1'b1;
      end
      if (3'(i) == r_cur) begin
        w_valid_cur = ch_valid[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50M_o or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_mask    <= '0;
      r_ch_en   <= '0;
      r_gap     <= '0;
      r_gap_cnt <= '0;
      r_repeat  <= '0;
      r_pass    <= '0;
      r_cur     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      r_tmo     <= '0;
      r_tmo_cnt <= '0;
`endif
    end else begin
      r_ch_en <= '0;
      r_done  <= 1'b0;
      // Busy trails the state by one edge so it drops one cycle after seq_done.
      r_busy  <= (r_state != S_IDLE);
      if (abort && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start && !abort && !r_busy) begin
              r_mask    <= ch_mask;
              r_gap     <= gap_cycles;
              r_repeat  <= repeat_num;
              r_pass    <= '0;
              r_cur     <= w_first_new;
              r_err     <= (ch_mask == '0);
              r_state   <= (ch_mask == '0) ? S_DONE : S_ARM;
`ifdef SEQ_TIMEOUT_EN
              r_tmo     <= tmo_cycles;
`endif
            end
          end
          S_ARM: begin
            r_ch_en   <= w_onehot;
            r_gap_cnt <= '0;
            r_state   <= S_WAIT;
`ifdef SEQ_TIMEOUT_EN
            r_tmo_cnt <= '0;
`endif
          end
          S_WAIT: begin
            if (w_valid_cur) begin
              r_state <= S_GAP;
            end else if (w_tmo_hit) begin
              r_err   <= 1'b1;
              r_state <= S_GAP;
            end
`ifdef SEQ_TIMEOUT_EN
            else begin
              r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end
`endif
          end
          S_GAP: begin
            if (w_gap_end) r_state <= S_NEXT;
            else           r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
          S_NEXT: begin
            if (w_has_next) begin
              r_cur   <= w_next;
              r_state <= S_ARM;
            end else begin
              r_pass <= r_pass + 8'd1;
              if ((r_repeat != 8'd0) && (r_pass + 8'd1 == r_repeat)) begin
                r_state <= S_DONE;
              end else begin
                r_cur   <= w_first;
                r_state <= S_ARM;
              end
            end
          end
          S_DONE: begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign ch_en    = r_ch_en;
  assign seq_busy = r_busy;
  assign seq_done = r_done;
  assign seq_err  = r_err;
  assign cur_ch   = r_cur;
  assign pass_cnt = r_pass;

endmodule

// File: tb/tb_pwm_seq_scheduler.sv
// Directed self-checking bench for pwm_seq_scheduler (NUM_CH=3).
// Exercises the SEQ_TIMEOUT_EN path when that macro is defined.
module tb_pwm_seq_scheduler;

  logic        clk_50M_o = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [2:0]  ch_mask = '0;
  logic [15:0] gap_cycles = '0;
  logic [7:0]  repeat_num = '0;
  logic [23:0] tmo_cycles = '0;
  logic [2:0]  ch_busy = '0;
  logic [2:0]  ch_valid = '0;
  logic [2:0]  ch_en;
  logic        seq_busy;
  logic        seq_done;
  logic        seq_err;
  logic [2:0]  cur_ch;
  logic [7:0]  pass_cnt;

  int checks = 0;
  int failures = 0;
  int n_en = 0;
  int n_done = 0;

  always #10 clk_50M_o = ~clk_50M_o;

  pwm_seq_scheduler #(.NUM_CH(3), .GAP_W(16), .TMO_W(24)) dut (
    .clk_50M_o (clk_50M_o),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .ch_mask   (ch_mask),
    .gap_cycles(gap_cycles),
    .repeat_num(repeat_num),
    .tmo_cycles(tmo_cycles),
    .ch_busy   (ch_busy),
    .ch_valid  (ch_valid),
    .ch_en     (ch_en),
    .seq_busy  (seq_busy),
    .seq_done  (seq_done),
    .seq_err   (seq_err),
    .cur_ch    (cur_ch),
    .pass_cnt  (pass_cnt)
  );

  always @(negedge clk_50M_o) begin
    if (ch_en != 3'b000) n_en++;
    if (seq_done) n_done++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_50M_o);
    #1;
  endtask

  task automatic go(input logic [2:0] m, input logic [15:0] g, input logic [7:0] r, input logic [23:0] t);
    ch_mask = m; gap_cycles = g; repeat_num = r; tmo_cycles = t;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_en(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (ch_en == 3'b000 && n < 400);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!seq_done && n < 400);
  endtask

  int n;
  int base_en;
  int base_done;
  int bad;
  int ord[6] = '{0, 1, 2, 0, 1, 2};
  int pexp[6] = '{0, 0, 0, 1, 1, 1};
  logic [23:0] t1_tmo;

  initial begin
`ifdef SEQ_TIMEOUT_EN
    t1_tmo = 24'd0;
`else
    t1_tmo = 24'd5;
`endif
    // Reset state
    tick(); tick();
    check("rst_ch_en", 32'(ch_en), 32'h0);
    check("rst_busy", 32'(seq_busy), 32'h0);
    check("rst_done", 32'(seq_done), 32'h0);
    check("rst_err", 32'(seq_err), 32'h0);
    check("rst_cur", 32'(cur_ch), 32'h0);
    check("rst_pass", 32'(pass_cnt), 32'h0);
    rst_n = 1'b1;
    tick();

    // Test 1: mask 101, gap 4, repeat 1
    base_en = n_en; base_done = n_done;
    go(3'b101, 16'd4, 8'd1, t1_tmo);
    check("t1_busy_at_T", 32'(seq_busy), 32'h0);
    check("t1_en_at_T", 32'(ch_en), 32'h0);
    wait_en(n);
    check("t1_lat0", 32'(n), 32'd1);
    check("t1_en0", 32'(ch_en), 32'h1);
    check("t1_cur0", 32'(cur_ch), 32'h0);
    check("t1_busy", 32'(seq_busy), 32'h1);
    repeat (4) tick();
    ch_valid = 3'b100;
    tick();
    ch_valid = 3'b000;
    repeat (4) tick();
    ch_valid = 3'b001;
    tick();
    ch_valid = 3'b000;
    check("t1_en_off", 32'(ch_en), 32'h0);
    start = 1'b1; ch_mask = 3'b010;
    tick();
    start = 1'b0; ch_mask = 3'b101;
    wait_en(n);
    check("t1_lat1", 32'(n), 32'd5);
    check("t1_en1", 32'(ch_en), 32'h4);
    check("t1_cur1", 32'(cur_ch), 32'h2);
    repeat (9) tick();
    ch_valid = 3'b100;
    tick();
    ch_valid = 3'b000;
    wait_done(n);
    check("t1_done_lat", 32'(n), 32'd6);
    check("t1_pass", 32'(pass_cnt), 32'h1);
    check("t1_err", 32'(seq_err), 32'h0);
    check("t1_busy_done", 32'(seq_busy), 32'h1);
    tick();
    check("t1_done_off", 32'(seq_done), 32'h0);
    check("t1_busy_off", 32'(seq_busy), 32'h0);
    check("t1_n_done", 32'(n_done - base_done), 32'd1);
    check("t1_n_en", 32'(n_en - base_en), 32'd2);

    // Test 2: mask 111, gap 0, repeat 2
    base_en = n_en; base_done = n_done;
    go(3'b111, 16'd0, 8'd2, 24'd0);
    for (int k = 0; k < 6; k++) begin
      wait_en(n);
      check("t2_lat", 32'(n), (k == 0) ? 32'd1 : 32'd3);
      check("t2_en", 32'(ch_en), 32'd1 << ord[k]);
      check("t2_cur", 32'(cur_ch), 32'(ord[k]));
      check("t2_pass", 32'(pass_cnt), 32'(pexp[k]));
      tick();
      ch_valid = 3'(1 << ord[k]);
      tick();
      ch_valid = 3'b000;
    end
    wait_done(n);
    check("t2_done_lat", 32'(n), 32'd3);
    check("t2_pass_end", 32'(pass_cnt), 32'h2);
    tick();
    check("t2_busy_off", 32'(seq_busy), 32'h0);
    check("t2_n_done", 32'(n_done - base_done), 32'd1);
    check("t2_n_en", 32'(n_en - base_en), 32'd6);

    // Test 3: empty mask
    base_en = n_en;
    go(3'b000, 16'd3, 8'd1, 24'd0);
    check("t3_done_T", 32'(seq_done), 32'h0);
    check("t3_err_T", 32'(seq_err), 32'h1);
    tick();
    check("t3_done", 32'(seq_done), 32'h1);
    check("t3_busy", 32'(seq_busy), 32'h1);
    check("t3_en", 32'(ch_en), 32'h0);
    tick();
    check("t3_done_off", 32'(seq_done), 32'h0);
    check("t3_busy_off", 32'(seq_busy), 32'h0);
    check("t3_err_hold", 32'(seq_err), 32'h1);
    check("t3_n_en", 32'(n_en - base_en), 32'd0);

    // Test 4: infinite repeat, abort after third ch_en
    base_en = n_en; base_done = n_done;
    go(3'b010, 16'd2, 8'd0, 24'd0);
    for (int k = 0; k < 3; k++) begin
      wait_en(n);
      check("t4_lat", 32'(n), (k == 0) ? 32'd1 : 32'd4);
      check("t4_cur", 32'(cur_ch), 32'h1);
      check("t4_pass", 32'(pass_cnt), 32'(k));
      if (k < 2) begin
        tick();
        ch_valid = 3'b010;
        tick();
        ch_valid = 3'b000;
      end
    end
    check("t4_err_clr", 32'(seq_err), 32'h0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_busy_A", 32'(seq_busy), 32'h1);
    tick();
    check("t4_busy_A1", 32'(seq_busy), 32'h0);
    repeat (5) tick();
    check("t4_n_done", 32'(n_done - base_done), 32'd0);
    check("t4_n_en", 32'(n_en - base_en), 32'd3);
    check("t4_pass_hold", 32'(pass_cnt), 32'h2);

    // Test 5: pass_cnt wrap in infinite mode, valid held high
    go(3'b001, 16'd0, 8'd0, 24'd0);
    ch_valid = 3'b001;
    bad = 0;
    for (int k = 1; k <= 257; k++) begin
      wait_en(n);
      if (k > 1 && n != 4) bad++;
      if (k == 256) check("t5_pass255", 32'(pass_cnt), 32'd255);
      if (k == 257) check("t5_pass_wrap", 32'(pass_cnt), 32'd0);
    end
    check("t5_period_errs", 32'(bad), 32'd0);
    ch_valid = 3'b000;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    check("t5_busy_off", 32'(seq_busy), 32'h0);

`ifdef SEQ_TIMEOUT_EN
    // Test 6: timeout on channel 0
    go(3'b011, 16'd0, 8'd1, 24'd100);
    wait_en(n);
    check("t6_lat0", 32'(n), 32'd1);
    n = 0;
    do begin
      tick();
      n++;
    end while (!seq_err && n < 200);
    check("t6_tmo_lat", 32'(n), 32'd101);
    wait_en(n);
    check("t6_lat1", 32'(n), 32'd3);
    check("t6_cur1", 32'(cur_ch), 32'h1);
    tick();
    ch_valid = 3'b010;
    tick();
    ch_valid = 3'b000;
    wait_done(n);
    check("t6_done_lat", 32'(n), 32'd3);
    check("t6_err_sticky", 32'(seq_err), 32'h1);
    tick();
`endif

    // Test 7: reset during GAP, then clean rerun
    go(3'b110, 16'd10, 8'd1, 24'd0);
    wait_en(n);
    check("t7_cur", 32'(cur_ch), 32'h1);
    tick();
    ch_valid = 3'b010;
    tick();
    ch_valid = 3'b000;
    repeat (3) tick();
    check("t7_busy_pre", 32'(seq_busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("t7_rst_en", 32'(ch_en), 32'h0);
    check("t7_rst_busy", 32'(seq_busy), 32'h0);
    check("t7_rst_done", 32'(seq_done), 32'h0);
    check("t7_rst_err", 32'(seq_err), 32'h0);
    check("t7_rst_cur", 32'(cur_ch), 32'h0);
    check("t7_rst_pass", 32'(pass_cnt), 32'h0);
    tick(); tick();
    #5 rst_n = 1'b1;
    base_en = n_en; base_done = n_done;
    repeat (3) tick();
    check("t7_post_en", 32'(n_en - base_en), 32'd0);
    check("t7_post_busy", 32'(seq_busy), 32'h0);
    go(3'b001, 16'd0, 8'd1, 24'd0);
    wait_en(n);
    check("t7_lat", 32'(n), 32'd1);
    check("t7_en", 32'(ch_en), 32'h1);
    tick();
    ch_valid = 3'b001;
    tick();
    ch_valid = 3'b000;
    wait_done(n);
    check("t7_done_lat", 32'(n), 32'd3);
    check("t7_pass", 32'(pass_cnt), 32'h1);
    check("t7_err", 32'(seq_err), 32'h0);
    tick();
    check("t7_n_done", 32'(n_done - base_done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
